wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Write-back arbiter: NUM_REQ single-entry request buffers merged onto two
// register-file write ports with round-robin priority and same-address hazard avoidance.
module wb_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      reg_write_en_1,
    output logic [ADDR_W-1:0]         reg_write_addr_1,
    output logic [DATA_W-1:0]         reg_write_data_1,
    output logic                      reg_write_en_2,
    output logic [ADDR_W-1:0]         reg_write_addr_2,
    output logic [DATA_W-1:0]         reg_write_data_2,
    output logic                      busy
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: requester i transfers on a rising edge where req_valid[i] and
    // req_ready[i] are both high; ready never depends on req_valid.
    logic [NUM_REQ-1:0] ent_valid;
    logic [ADDR_W-1:0]  ent_addr [NUM_REQ];
    logic [DATA_W-1:0]  ent_data [NUM_REQ];
    logic [PTR_W-1:0]   rr_ptr;
    logic               run;

    logic               g1_found, g2_found;
    logic [PTR_W-1:0]   g1_idx, g2_idx, idx;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] xfer;

    // Scan from rr_ptr; port 2 skips entries that collide with the port-1 address.
    always_comb begin
        g1_found = 1'b0;
        g2_found = 1'b0;
        g1_idx   = '0;
        g2_idx   = '0;
        idx      = '0;
        grant    = '0;
        if (!flush) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
                if (ent_valid[idx]) begin
                    if (!g1_found) begin
                        g1_found    = 1'b1;
                        g1_idx      = idx;
                        grant[idx]  = 1'b1;
                    end else if (!g2_found && (ent_addr[idx] != ent_addr[g1_idx])) begin
                        g2_found    = 1'b1;
                        g2_idx      = idx;
                        grant[idx]  = 1'b1;
                    end
                end
            end
        end
    end

    assign req_ready = {NUM_REQ{run && !flush}} & (~ent_valid | grant);
    assign xfer      = req_valid & req_ready;
    assign busy      = (|ent_valid) | reg_write_en_1 | reg_write_en_2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid        <= '0;
            rr_ptr           <= '0;
            run              <= 1'b0;
            reg_write_en_1   <= 1'b0;
            reg_write_addr_1 <= '0;
            reg_write_data_1 <= '0;
            reg_write_en_2   <= 1'b0;
            reg_write_addr_2 <= '0;
            reg_write_data_2 <= '0;
        end else begin
            run <= 1'b1;
            if (flush) begin
                ent_valid      <= '0;
                reg_write_en_1 <= 1'b0;
                reg_write_en_2 <= 1'b0;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (xfer[i]) begin
                        ent_valid[i] <= 1'b1;
                    end else if (grant[i]) begin
                        ent_valid[i] <= 1'b0;
                    end
                end
                reg_write_en_1 <= g1_found;
                reg_write_en_2 <= g2_found;
                if (g1_found) begin
                    reg_write_addr_1 <= ent_addr[g1_idx];
                    reg_write_data_1 <= ent_data[g1_idx];
                end
                if (g2_found) begin
                    reg_write_addr_2 <= ent_addr[g2_idx];
                    reg_write_data_2 <= ent_data[g2_idx];
                end
                if (g2_found) begin
                    rr_ptr <= PTR_W'((int'(g2_idx) + 1) % NUM_REQ);
                end else if (g1_found) begin
                    rr_ptr <= PTR_W'((int'(g1_idx) + 1) % NUM_REQ);
                end
            end
        end
    end

    // Payload storage needs no reset: it is only observed behind ent_valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer[i]) begin
                ent_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
                ent_data[i] <= req_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized scoreboard bench for wb_port_arbiter against a round-robin reference model.
module tb_wb_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 7;
    localparam int DW = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              reg_write_en_1, reg_write_en_2;
    logic [AW-1:0]     reg_write_addr_1, reg_write_addr_2;
    logic [DW-1:0]     reg_write_data_1, reg_write_data_2;
    logic              busy;

    wb_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .reg_write_en_1(reg_write_en_1), .reg_write_addr_1(reg_write_addr_1),
        .reg_write_data_1(reg_write_data_1),
        .reg_write_en_2(reg_write_en_2), .reg_write_addr_2(reg_write_addr_2),
        .reg_write_data_2(reg_write_data_2),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected writes per port, {addr, data}.
    logic [AW+DW-1:0] exp_q1[$];
    logic [AW+DW-1:0] exp_q2[$];
    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit            m_v [N];
    logic [AW-1:0] m_a [N];
    logic [DW-1:0] m_d [N];
    int            m_rr;
    bit            m_run;
    bit            m_en1, m_en2;

    task automatic check(input string name, input logic [AW+DW-1:0] act,
                         input logic [AW+DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_v[i] = 1'b0;
        m_rr  = 0;
        m_run = 1'b0;
        m_en1 = 1'b0;
        m_en2 = 1'b0;
    endtask

    // Predict ready/busy for this cycle, then advance the model across the next edge.
    task automatic model_cycle();
        int g1, g2, i;
        logic [N-1:0] er;
        bit busy_e;
        g1 = -1;
        g2 = -1;
        for (int k = 0; k < N; k++) begin
            i = (m_rr + k) % N;
            if (m_v[i]) begin
                if (g1 < 0) g1 = i;
                else if (g2 < 0 && m_a[i] != m_a[g1]) g2 = i;
            end
        end
        if (flush) begin
            g1 = -1;
            g2 = -1;
        end
        busy_e = m_en1 || m_en2;
        for (int j = 0; j < N; j++) busy_e = busy_e || m_v[j];
        for (int j = 0; j < N; j++)
            er[j] = m_run && !flush && (!m_v[j] || j == g1 || j == g2);
        check("req_ready", (AW+DW)'(req_ready), (AW+DW)'(er));
        check("busy", (AW+DW)'(busy), (AW+DW)'(busy_e));
        if (flush) begin
            for (int j = 0; j < N; j++) m_v[j] = 1'b0;
            m_en1 = 1'b0;
            m_en2 = 1'b0;
        end else begin
            m_en1 = (g1 >= 0);
            m_en2 = (g2 >= 0);
            if (g1 >= 0) begin
                exp_q1.push_back({m_a[g1], m_d[g1]});
                m_v[g1] = 1'b0;
                m_rr = (g1 + 1) % N;
            end
            if (g2 >= 0) begin
                exp_q2.push_back({m_a[g2], m_d[g2]});
                m_v[g2] = 1'b0;
                m_rr = (g2 + 1) % N;
            end
            for (int j = 0; j < N; j++) begin
                if (req_valid[j] && er[j]) begin
                    m_v[j] = 1'b1;
                    m_a[j] = req_addr[j*AW +: AW];
                    m_d[j] = req_data[j*DW +: DW];
                end
            end
        end
        m_run = 1'b1;
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", (AW+DW)'(req_ready), '0);
        check("rst_busy", (AW+DW)'(busy), '0);
        check("rst_port1", {reg_write_addr_1, reg_write_data_1} | (AW+DW)'(reg_write_en_1), '0);
        check("rst_port2", {reg_write_addr_2, reg_write_data_2} | (AW+DW)'(reg_write_en_2), '0);
    endtask

    task automatic drive_idle();
        flush     = 1'b0;
        req_valid = '0;
    endtask

    task automatic drive_random();
        flush = ($urandom_range(0, 24) == 0);
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = ($urandom_range(0, 2) != 0);
            req_addr[i*AW +: AW]   = AW'($urandom_range(0, 5));
            req_data[i*DW +: DW]   = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic drive_all_distinct();
        flush     = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = AW'(16 + i);
            req_data[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // Monitor: pops an expected write whenever a port enable is seen.
    logic [AW+DW-1:0] last1 = '0, last2 = '0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            last1 = '0;
            last2 = '0;
        end else begin
            if (reg_write_en_1) begin
                if (exp_q1.size() == 0) begin
                    check("port1_unexpected", {reg_write_addr_1, reg_write_data_1}, 'x);
                end else begin
                    last1 = exp_q1.pop_front();
                    check("port1_write", {reg_write_addr_1, reg_write_data_1}, last1);
                end
            end else begin
                check("port1_hold", {reg_write_addr_1, reg_write_data_1}, last1);
            end
            if (reg_write_en_2) begin
                if (exp_q2.size() == 0) begin
                    check("port2_unexpected", {reg_write_addr_2, reg_write_data_2}, 'x);
                end else begin
                    last2 = exp_q2.pop_front();
                    check("port2_write", {reg_write_addr_2, reg_write_data_2}, last2);
                end
            end else begin
                check("port2_hold", {reg_write_addr_2, reg_write_data_2}, last2);
            end
            if (reg_write_en_1 && reg_write_en_2)
                check("port_addr_distinct", (AW+DW)'(reg_write_addr_1 == reg_write_addr_2), '0);
        end
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (c == 600 || c == 1100) begin
                rst = 1'b1;
                #1;
                check_reset_outputs();
                model_reset();
                repeat (2) @(negedge clk);
            end
            rst = 1'b0;
            if (c == 0) begin
                drive_idle();
                req_valid[0]      = 1'b1;
                req_addr[0 +: AW] = AW'(5);
                req_data[0 +: DW] = {DW/8{8'hAA}};
            end else if (c < 4 || c >= 1450) begin
                drive_idle();
            end else if (c >= 100 && c < 160) begin
                drive_all_distinct();
            end else begin
                drive_random();
            end
            #1;
            model_cycle();
        end
        @(negedge clk);
        check("port1_drained", (AW+DW)'(exp_q1.size()), '0);
        check("port2_drained", (AW+DW)'(exp_q2.size()), '0);
        check("idle_busy", (AW+DW)'(busy), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
